reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which is the synchronizer depth for asynchronous inputs (legal values 2 to 4).
REQ-002 SHALL have parameter NUM_STAGES, default 3, which is the number of downstream reset domains (legal values 1 to 8).
REQ-003 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port nreset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ready_in  in  1  startup-complete level, asynchronous to clock.
REQ-006 SHALL have port pll_locked  in  1  PLL lock level, asynchronous to clock.
REQ-007 SHALL have port stage_delay  in  16  spacing between stage events, in cycles minus one; quasi-static, changed only while state is IDLE.
REQ-008 SHALL have port nreset_stage  out  NUM_STAGES  per-domain active-low reset, registered.
REQ-009 SHALL have port running  out  1  high while all stages are released.
REQ-010 SHALL have port fault  out  1  sticky flag for lock lost while running.

Function
REQ-011 SHALL synchronize ready_in and pll_locked each through SYNC_STAGES flops, then define enable = ready_s AND locked_s.
REQ-012 SHALL implement states IDLE, RELEASE, RUN and SHUTDOWN, with a 16-bit counter cnt and a stage index idx.
REQ-013 SHALL behave in IDLE as follows:
- all nreset_stage are 0.
- cnt increments while enable is 1 and clears to 0 whenever enable is 0.
- on an edge where enable=1 and cnt==stage_delay: set nreset_stage[0]=1, clear cnt, set idx=0, and enter RELEASE (or RUN if NUM_STAGES=1).
REQ-014 SHALL release nreset_stage[0] on the (SYNC_STAGES+stage_delay+1)th rising edge, counting as the 1st the first edge that samples both ready_in and pll_locked high.
REQ-015 SHALL behave in RELEASE as follows:
- cnt increments each cycle.
- when cnt==stage_delay: set nreset_stage[idx+1]=1, increment idx, clear cnt.
- if the stage just released is NUM_STAGES-1, enter RUN and set running=1 on the same edge.
REQ-016 SHALL space consecutive release events exactly stage_delay+1 cycles apart; stage_delay=0 gives one stage per cycle.
REQ-017 SHALL, in RELEASE or RUN with enable=0, enter SHUTDOWN on the next edge:
- running=0, cnt cleared.
- the highest released stage is reasserted (set to 0) on that same edge.
REQ-018 SHALL set fault=1 on the RUN->SHUTDOWN edge when locked_s=0, and hold fault until nreset; a drop of ready_in alone does not set fault.
REQ-019 SHALL, in SHUTDOWN, reassert the remaining released stages in descending index order, stage_delay+1 cycles apart, and enter IDLE (cnt=0) on the edge that asserts nreset_stage[0].
REQ-020 SHALL ignore enable during SHUTDOWN; the sequence completes even if enable returns, and IDLE then requalifies from cnt=0.
REQ-021 SHALL guarantee that nreset_stage is always of the form: stages 0..k released, all others asserted (never non-contiguous).
REQ-022 SHALL use equality compares only for cnt; cnt never exceeds stage_delay, so no wrap occurs.

Reset
REQ-023 SHALL, while nreset=0 (asynchronous, active-low), force the following and hold them until the first rising edge after release:
- state=IDLE, cnt=0, idx=0.
- nreset_stage=0, running=0, fault=0.
- all synchronizer flops 0.
REQ-024 SHALL, on nreset assertion mid-RELEASE, mid-RUN or mid-SHUTDOWN, assert all stages immediately with no ordered shutdown.

Structure
REQ-025 SHALL keep the state encoding constants and the SYNC_STAGES/NUM_STAGES defaults in a shared package.
REQ-026 SHALL use one sub-module, bit_sync (parameterized depth, async clear), instantiated once for ready_in and once for pll_locked.

Verification
Common setup: SYNC_STAGES=2, NUM_STAGES=3.
REQ-027 SHALL cover: stage_delay=4, raise ready_in and pll_locked before edge 1 -> nreset_stage bits 0/1/2 rise at edges 7/12/17, and running rises at edge 17.
REQ-028 SHALL cover: stage_delay=0 -> stages release on edges 3/4/5, running at edge 5.
REQ-029 SHALL cover: stage_delay=4, in RUN drop pll_locked -> stage2 falls 3 edges later, stage1 5 edges after that, stage0 5 edges after that with IDLE entered, fault=1 and held.
REQ-030 SHALL cover: in RUN drop ready_in only -> same ordered shutdown and fault stays 0.
REQ-031 SHALL cover: stage_delay=4, ready_in pulses low for 2 cycles during IDLE qualification -> cnt restarts and stage0 release is delayed accordingly.
REQ-032 SHALL cover: assert nreset during RELEASE with stages 0 and 1 released -> all outputs 0 immediately; after release, the sequence restarts from IDLE.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: sequencer states and the
// default synchronizer depth / reset domain count.
package reset_sequencer_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_NUM_STAGES  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RELEASE  = 2'd1,
    RUN      = 2'd2,
    SHUTDOWN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reset_sequencer_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level input.
// The whole chain clears asynchronously, so a synchronized level of 1
// can only appear after nreset has been released.
module bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic nreset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // Shift the raw input through DEPTH flops, cleared while in reset
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release/reassert sequencer. Once the synchronized
// startup-ready and PLL-lock levels are both high for stage_delay+1
// cycles, downstream reset domains are released one by one in ascending
// order. Losing either level reasserts them in descending order. The
// release mask is kept as a thermometer code (shift in / shift out), so
// it is always contiguous from stage 0.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int NUM_STAGES  = DEFAULT_NUM_STAGES
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  ready_in,
  input  logic                  pll_locked,
  input  logic [15:0]           stage_delay,
  output logic [NUM_STAGES-1:0] nreset_stage,
  output logic                  running,
  output logic                  fault
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic ready_s;
  logic locked_s;
  logic enable;

  seq_state_e            state_q,   state_d;
  logic [15:0]           cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [NUM_STAGES-1:0] stages_q,  stages_d;
  logic                  running_q, running_d;
  logic                  fault_q,   fault_d;

  bit_sync #(.DEPTH(SYNC_STAGES)) u_ready_sync (
    .clock  (clock),
    .nreset (nreset),
    .d_i    (ready_in),
    .q_o    (ready_s)
  );

  bit_sync #(.DEPTH(SYNC_STAGES)) u_locked_sync (
    .clock  (clock),
    .nreset (nreset),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign enable = ready_s & locked_s;

  // State, counter, stage mask and flag registers; reset asserts every stage at once
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stages_q  <= '0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stages_q  <= stages_d;
      running_q <= running_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic: idx always names the highest stage currently released
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    stages_d  = stages_q;
    running_d = running_q;
    fault_d   = fault_q;

    case (state_q)
      IDLE: begin
        stages_d  = '0;
        running_d = 1'b0;
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == stage_delay) begin
          stages_d = NUM_STAGES'(1);
          cnt_d    = '0;
          idx_d    = '0;
          if (NUM_STAGES == 1) begin
            state_d   = RUN;
            running_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RELEASE, RUN: begin
        if (!enable) begin
          if (state_q == RUN && !locked_s) begin
            fault_d = 1'b1;
          end
          running_d = 1'b0;
          cnt_d     = '0;
          stages_d  = stages_q >> 1;
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SHUTDOWN;
          end
        end else if (state_q == RELEASE) begin
          if (cnt_q == stage_delay) begin
            stages_d = (stages_q << 1) | NUM_STAGES'(1);
            cnt_d    = '0;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q + IDX_W'(1) == IDX_W'(NUM_STAGES - 1)) begin
              state_d   = RUN;
              running_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      SHUTDOWN: begin
        running_d = 1'b0;
        if (cnt_q == stage_delay) begin
          stages_d = stages_q >> 1;
          cnt_d    = '0;
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign nreset_stage = stages_q;
  assign running      = running_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with SYNC_STAGES=2, NUM_STAGES=3.
// Edge numbers in the vectors count from the first rising edge after the
// inputs are raised.
module tb_reset_sequencer;

  logic        clock;
  logic        nreset;
  logic        readyIn;
  logic        pllLocked;
  logic [15:0] stageDelay;
  logic [2:0]  nresetStage;
  logic        running;
  logic        fault;

  int testsRun;
  int testsFailed;

  typedef struct {
    string      name;
    logic       readyIn;
    logic       pllLocked;
    int         edges;
    logic [2:0] expStages;
    logic       expRun;
    logic       expFault;
  } vec_t;

  vec_t vecs[$];

  reset_sequencer #(
    .SYNC_STAGES (2),
    .NUM_STAGES  (3)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .ready_in     (readyIn),
    .pll_locked   (pllLocked),
    .stage_delay  (stageDelay),
    .nreset_stage (nresetStage),
    .running      (running),
    .fault        (fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mkVec(string n, logic r, logic l, int e,
                                 logic [2:0] s, logic rn, logic f);
    vec_t v;
    v.name      = n;
    v.readyIn   = r;
    v.pllLocked = l;
    v.edges     = e;
    v.expStages = s;
    v.expRun    = rn;
    v.expFault  = f;
    return v;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input int edges);
    readyIn   = r;
    pllLocked = l;
    tick(edges);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expStages,
                             input logic expRun, input logic expFault);
    testsRun++;
    if (nresetStage !== expStages || running !== expRun || fault !== expFault) begin
      testsFailed++;
      $display("[TB] FAIL %s: got stages=%b running=%b fault=%b, expected stages=%b running=%b fault=%b",
               name, nresetStage, running, fault, expStages, expRun, expFault);
    end
  endtask

  // Hold reset for two edges with the inputs low, load the delay, then release
  task automatic applyReset(input logic [15:0] delay);
    nreset     = 1'b0;
    readyIn    = 1'b0;
    pllLocked  = 1'b0;
    stageDelay = delay;
    tick(2);
    checkOutput("held in reset", 3'b000, 1'b0, 1'b0);
    nreset = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    nreset      = 1'b0;
    readyIn     = 1'b0;
    pllLocked   = 1'b0;
    stageDelay  = 16'd4;

    // Power-up release, ordered shutdown on lock loss, then requalification
    vecs.push_back(mkVec("idle no enable",     0, 0,  3, 3'b000, 0, 0));
    vecs.push_back(mkVec("up edge6",           1, 1,  6, 3'b000, 0, 0));
    vecs.push_back(mkVec("up edge7 stage0",    1, 1,  1, 3'b001, 0, 0));
    vecs.push_back(mkVec("up edge11",          1, 1,  4, 3'b001, 0, 0));
    vecs.push_back(mkVec("up edge12 stage1",   1, 1,  1, 3'b011, 0, 0));
    vecs.push_back(mkVec("up edge16",          1, 1,  4, 3'b011, 0, 0));
    vecs.push_back(mkVec("up edge17 running",  1, 1,  1, 3'b111, 1, 0));
    vecs.push_back(mkVec("run steady",         1, 1,  5, 3'b111, 1, 0));
    vecs.push_back(mkVec("unlock +2",          1, 0,  2, 3'b111, 1, 0));
    vecs.push_back(mkVec("unlock +3 stage2",   1, 0,  1, 3'b011, 0, 1));
    vecs.push_back(mkVec("unlock +7",          1, 0,  4, 3'b011, 0, 1));
    vecs.push_back(mkVec("unlock +8 stage1",   1, 0,  1, 3'b001, 0, 1));
    vecs.push_back(mkVec("unlock +12",         1, 0,  4, 3'b001, 0, 1));
    vecs.push_back(mkVec("unlock +13 idle",    1, 0,  1, 3'b000, 0, 1));
    vecs.push_back(mkVec("idle fault held",    1, 0, 10, 3'b000, 0, 1));
    vecs.push_back(mkVec("relock edge6",       1, 1,  6, 3'b000, 0, 1));
    vecs.push_back(mkVec("relock edge7",       1, 1,  1, 3'b001, 0, 1));

    tick(1);
    checkOutput("reset state", 3'b000, 1'b0, 1'b0);

    applyReset(16'd4);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].readyIn, vecs[i].pllLocked, vecs[i].edges);
      checkOutput(vecs[i].name, vecs[i].expStages, vecs[i].expRun, vecs[i].expFault);
    end

    // stage_delay=0: one stage per cycle on edges 3/4/5
    applyReset(16'd0);
    applyStimulus(1, 1, 2);
    checkOutput("d0 edge2", 3'b000, 1'b0, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("d0 edge3", 3'b001, 1'b0, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("d0 edge4", 3'b011, 1'b0, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("d0 edge5", 3'b111, 1'b1, 1'b0);

    // ready_in drop alone: same ordered shutdown, no fault
    applyReset(16'd4);
    applyStimulus(1, 1, 17);
    checkOutput("rdy up edge17", 3'b111, 1'b1, 1'b0);
    applyStimulus(0, 1, 2);
    checkOutput("rdy drop +2", 3'b111, 1'b1, 1'b0);
    applyStimulus(0, 1, 1);
    checkOutput("rdy drop +3", 3'b011, 1'b0, 1'b0);
    applyStimulus(0, 1, 5);
    checkOutput("rdy drop +8", 3'b001, 1'b0, 1'b0);
    applyStimulus(0, 1, 5);
    checkOutput("rdy drop +13", 3'b000, 1'b0, 1'b0);

    // ready_in glitches low for two cycles during qualification: release moves to edge 12
    applyReset(16'd4);
    applyStimulus(1, 1, 3);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 1, 2);
    checkOutput("glitch edge7", 3'b000, 1'b0, 1'b0);
    applyStimulus(1, 1, 4);
    checkOutput("glitch edge11", 3'b000, 1'b0, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("glitch edge12", 3'b001, 1'b0, 1'b0);

    // Asynchronous reset mid-RELEASE with stages 0 and 1 out, then restart
    applyReset(16'd4);
    applyStimulus(1, 1, 14);
    checkOutput("mid release", 3'b011, 1'b0, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    checkOutput("async reset", 3'b000, 1'b0, 1'b0);
    tick(2);
    checkOutput("async reset held", 3'b000, 1'b0, 1'b0);
    #2;
    nreset = 1'b1;
    applyStimulus(1, 1, 6);
    checkOutput("restart edge6", 3'b000, 1'b0, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("restart edge7", 3'b001, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
